rc4_keysearch_core: RTL and testbench
=====================================

// Module: rc4_keysearch_core
// PURPOSE
// Parametrised brute-force RC4 key-search engine; next generation of the task-3 search FSM.
// Steps candidate keys from KEY_START by KEY_STEP up to KEY_LAST. Per key: init S, run KSA, run PRGA over the ciphertext.
// Accepts the first key whose plaintext bytes are all 'a'..'z' or ' '.
// Several instances, with interleaved KEY_START/KEY_STEP and a shared stop, form a multi-core cracker under ksa.
// PARAMETERS
// KEY_BYTES  3          secret key length in bytes; key byte 0 = most significant byte
// KEY_BITS   24         searched key width; upper KEY_BYTES*8-KEY_BITS key bits forced 0 (KEY_BITS <= 8*KEY_BYTES)
// MSG_LEN    32         ciphertext/plaintext length in bytes (1..256)
// KEY_START  0          first candidate key
// KEY_STEP   1          candidate increment (>=1); = core count when interleaving
// KEY_LAST   2**KEY_BITS-1  last key eligible for testing
// PORTS
// clk        in   1          system clock (CLOCK_50)
// reset_n    in   1          asynchronous active-low reset
// start      in   1          1-cycle pulse; honoured only in IDLE/DONE
// stop       in   1          level; abort search (e.g. another core found key)
// s_addr     out  8          S RAM address
// s_wdata    out  8          S RAM write data
// s_wren     out  1          S RAM write enable
// s_q        in   8          S RAM read data, valid 1 cycle after s_addr (sync RAM)
// msg_addr   out  $clog2(MSG_LEN)  ciphertext ROM address
// msg_q      in   8          ciphertext ROM data, 1-cycle latency
// dec_addr   out  $clog2(MSG_LEN)  plaintext RAM address
// dec_wdata  out  8          plaintext byte
// dec_wren   out  1          plaintext RAM write enable
// cur_key    out  KEY_BITS   key under test (drives HEX display)
// found_key  out  KEY_BITS   accepted key; valid when found=1
// busy       out  1          search in progress
// done       out  1          search ended (found, failed or aborted); held until start/reset
// found      out  1          key accepted
// failed     out  1          range exhausted with no key accepted
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; cur_key=KEY_START.
// - States: IDLE -> INIT -> KSA -> PRGA -> (NEXT_KEY -> INIT | FOUND) ; NEXT_KEY -> FAIL at end of range.
// - start in IDLE/DONE: clear done/found/failed; cur_key=KEY_START; busy=1 next cycle; enter INIT.
// - INIT: 256 consecutive cycles of s_wren=1, s_addr=i, s_wdata=i, for i=0..255.
// - KSA (i=0..255): j=(j+S[i]+keybyte[i mod KEY_BYTES]) mod 256; swap S[i],S[j].
//   Sequence: read S[i] -> read S[j] -> write S[i]=S[j] -> write S[j]=S[i]. Each read waits its 1-cycle latency.
// - PRGA (k=0..MSG_LEN-1): i=i+1; j=j+S[i]; swap; f=S[(S[i]+S[j]) mod 256]; p=f^msg_q[k].
//   All arithmetic is 8-bit modulo 256. i and j are cleared to 0 at the start of KSA and again at the start of PRGA.
// - Each p is written once (dec_wren 1 cycle, dec_addr=k) and checked. Valid: 8'h61..8'h7A or 8'h20.
//   First invalid byte aborts PRGA immediately and goes to NEXT_KEY; the remaining bytes are not written.
// - All MSG_LEN bytes valid -> FOUND: found_key=cur_key, found=1, done=1, busy=0.
// - NEXT_KEY: if cur_key+KEY_STEP > KEY_LAST, or it overflows KEY_BITS (compare at KEY_BITS+1 width) -> FAIL: failed=1, done=1, busy=0, cur_key unchanged.
//   Otherwise cur_key += KEY_STEP and go to INIT.
// - stop=1 in any busy state: within 1 cycle s_wren=dec_wren=0, busy=0, done=1, found=failed=0.
//   A RAM write already issued completes; no further writes. stop in IDLE/DONE is ignored.
// - start while busy is ignored. start and stop in the same cycle: stop wins.
// - found and failed are never 1 together. s_wren and dec_wren are 0 outside INIT/KSA/PRGA.
// - reset_n low mid-operation returns to the reset state immediately; RAM contents are not restored.
// TESTING
// 1. Power-up: reset_n=0 then 1 -> busy=done=found=failed=0, s_wren=dec_wren=0, cur_key=KEY_START.
// 2. INIT: start pulse -> 256 writes observed, addr==data==0..255 in order.
// 3. Find: ROM = 32-byte lowercase text encrypted with key 24'h000249; KEY_START=24'h000240, KEY_STEP=1
//    -> found=1, found_key=24'h000249, dec RAM == plaintext, failed=0.
// 4. Exhaust: same ROM, KEY_START=0, KEY_LAST=24'h00000F -> failed=1, done=1, found=0, cur_key=24'h00000F.
// 5. Interleave: KEY_START=1, KEY_STEP=2 -> found_key=24'h000249. KEY_START=0, KEY_STEP=2, KEY_LAST=24'h0003FF -> failed=1.
// 6. Abort/reset: stop=1 mid-KSA -> next cycle busy=0, done=1, found=failed=0, no further writes.
//    reset_n=0 mid-PRGA -> outputs cleared asynchronously; a new start then repeats scenario 3.

Source files
------------

// File: rtl/rc4_keysearch_core_if.sv
// ----------------------------------------------------------------------------
// rc4_keysearch_core_if
// Bundles the control handshake, S RAM, ciphertext ROM and plaintext RAM
// signals of one RC4 key-search core.
//   master : the search core (drives RAM/ROM addresses and status)
//   slave  : the surrounding system (drives start/stop, returns RAM/ROM data)
// Signals:
//   start, stop                      control from the system
//   s_addr, s_wdata, s_wren, s_q     S RAM port (sync read, 1-cycle latency)
//   msg_addr, msg_q                  ciphertext ROM port (1-cycle latency)
//   dec_addr, dec_wdata, dec_wren    plaintext RAM write port
//   cur_key, found_key               key under test / accepted key
//   busy, done, found, failed        search status
// ----------------------------------------------------------------------------
interface rc4_keysearch_core_if #(
   parameter int KEY_BITS = 24,
   parameter int MSG_LEN  = 32
);
   localparam int MA_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   logic                start;
   logic                stop;
   logic [7:0]          s_addr;
   logic [7:0]          s_wdata;
   logic                s_wren;
   logic [7:0]          s_q;
   logic [MA_W-1:0]     msg_addr;
   logic [7:0]          msg_q;
   logic [MA_W-1:0]     dec_addr;
   logic [7:0]          dec_wdata;
   logic                dec_wren;
   logic [KEY_BITS-1:0] cur_key;
   logic [KEY_BITS-1:0] found_key;
   logic                busy;
   logic                done;
   logic                found;
   logic                failed;

   modport master (
      input  start, stop, s_q, msg_q,
      output s_addr, s_wdata, s_wren, msg_addr, dec_addr, dec_wdata, dec_wren,
             cur_key, found_key, busy, done, found, failed
   );

   modport slave (
      output start, stop, s_q, msg_q,
      input  s_addr, s_wdata, s_wren, msg_addr, dec_addr, dec_wdata, dec_wren,
             cur_key, found_key, busy, done, found, failed
   );
endinterface

// File: rtl/rc4_keysearch_core.sv
// ----------------------------------------------------------------------------
// rc4_keysearch_core
// Brute-force RC4 key search. Candidate keys run from KEY_START in steps of
// KEY_STEP up to KEY_LAST. For each key the S array is initialised, scrambled
// by the KSA, and the PRGA decrypts the ciphertext byte by byte. The first key
// whose plaintext consists only of 'a'..'z' and ' ' is accepted.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      rc4_keysearch_core_if.master (control, S RAM, ROM, plaintext RAM,
//            key and status outputs); all outputs are registered
// ----------------------------------------------------------------------------
module rc4_keysearch_core #(
   parameter int                  KEY_BYTES = 3,
   parameter int                  KEY_BITS  = 24,
   parameter int                  MSG_LEN   = 32,
   parameter logic [KEY_BITS-1:0] KEY_START = {KEY_BITS{1'b0}},
   parameter int unsigned         KEY_STEP  = 32'd1,
   parameter logic [KEY_BITS-1:0] KEY_LAST  = {KEY_BITS{1'b1}}
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rc4_keysearch_core_if.master bus
);
   localparam int MA_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int KBI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam int KB8   = KEY_BYTES * 8;
   localparam int KW1   = KEY_BITS + 1;

   // Rx = read address on the port, Lx = read data available on s_q,
   // Wx = write on the port.
   typedef enum logic [4:0] {
      ST_IDLE, ST_INIT,
      ST_KSA_RI, ST_KSA_LI, ST_KSA_RJ, ST_KSA_LJ, ST_KSA_WI, ST_KSA_WJ,
      ST_PRGA_RI, ST_PRGA_LI, ST_PRGA_RJ, ST_PRGA_LJ, ST_PRGA_WI, ST_PRGA_WJ,
      ST_PRGA_RF, ST_PRGA_LF, ST_PRGA_CHK,
      ST_NEXT_KEY, ST_DONE
   } state_t;

   state_t              state_q;
   logic [7:0]          i_q, j_q, si_q, sj_q, k_q;
   logic [KBI_W-1:0]    kb_idx_q;
   logic [7:0]          s_addr_q, s_wdata_q;
   logic                s_wren_q;
   logic [MA_W-1:0]     msg_addr_q, dec_addr_q;
   logic [7:0]          dec_wdata_q;
   logic                dec_wren_q;
   logic [KEY_BITS-1:0] cur_key_q, found_key_q;
   logic                busy_q, done_q, found_q, failed_q;

   logic [KB8-1:0]      key_full_d;
   logic [7:0]          key_byte_d;
   logic [KBI_W-1:0]    kb_idx_d;
   logic [7:0]          ksa_j_d, prga_j_d, i_inc_d, k_inc_d, f_idx_d, p_d;
   logic [KW1-1:0]      key_sum_d;
   logic                key_end_d;

   // Accepted plaintext alphabet: lowercase letters and space.
   function automatic logic is_text(input logic [7:0] b);
      is_text = ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   // Datapath arithmetic shared by the FSM (all byte math wraps mod 256).
   always_comb begin
      // Key bits above KEY_BITS are zero; byte 0 is the most significant.
      key_full_d = KB8'(cur_key_q);
      key_byte_d = 8'h00;
      for (int b = 0; b < KEY_BYTES; b++) begin
         key_byte_d = key_byte_d |
                      ((kb_idx_q == KBI_W'(b)) ? key_full_d[(KEY_BYTES-1-b)*8 +: 8] : 8'h00);
      end
      kb_idx_d  = (kb_idx_q == KBI_W'(KEY_BYTES-1)) ? {KBI_W{1'b0}} : kb_idx_q + KBI_W'(1);
      ksa_j_d   = j_q + bus.s_q + key_byte_d;
      prga_j_d  = j_q + bus.s_q;
      i_inc_d   = i_q + 8'd1;
      k_inc_d   = k_q + 8'd1;
      // After the swap S[i]+S[j] equals the pre-swap pair sum.
      f_idx_d   = si_q + sj_q;
      p_d       = bus.s_q ^ bus.msg_q;
      // One extra bit so a step past the top of the key space is caught.
      key_sum_d = {1'b0, cur_key_q} + KW1'(KEY_STEP);
      key_end_d = key_sum_d[KEY_BITS] || (key_sum_d > {1'b0, KEY_LAST});
   end

   // Search FSM with registered RAM/ROM and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         i_q         <= 8'h00;
         j_q         <= 8'h00;
         si_q        <= 8'h00;
         sj_q        <= 8'h00;
         k_q         <= 8'h00;
         kb_idx_q    <= {KBI_W{1'b0}};
         s_addr_q    <= 8'h00;
         s_wdata_q   <= 8'h00;
         s_wren_q    <= 1'b0;
         msg_addr_q  <= {MA_W{1'b0}};
         dec_addr_q  <= {MA_W{1'b0}};
         dec_wdata_q <= 8'h00;
         dec_wren_q  <= 1'b0;
         cur_key_q   <= KEY_START;
         found_key_q <= {KEY_BITS{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         failed_q    <= 1'b0;
      end else begin
         // Write strobes are single-cycle unless a state re-asserts them.
         s_wren_q   <= 1'b0;
         dec_wren_q <= 1'b0;
         if (busy_q && bus.stop) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            found_q  <= 1'b0;
            failed_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (bus.start && !bus.stop) begin
                     cur_key_q <= KEY_START;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                     found_q   <= 1'b0;
                     failed_q  <= 1'b0;
                     s_wren_q  <= 1'b1;
                     s_addr_q  <= 8'h00;
                     s_wdata_q <= 8'h00;
                     state_q   <= ST_INIT;
                  end else begin
                     state_q <= state_q;
                  end
               end
               ST_INIT: begin
                  if (s_addr_q == 8'hFF) begin
                     s_addr_q <= 8'h00;
                     i_q      <= 8'h00;
                     j_q      <= 8'h00;
                     kb_idx_q <= {KBI_W{1'b0}};
                     state_q  <= ST_KSA_RI;
                  end else begin
                     s_wren_q  <= 1'b1;
                     s_addr_q  <= s_addr_q + 8'd1;
                     s_wdata_q <= s_addr_q + 8'd1;
                  end
               end
               ST_KSA_RI: state_q <= ST_KSA_LI;
               ST_KSA_LI: begin
                  si_q     <= bus.s_q;
                  j_q      <= ksa_j_d;
                  s_addr_q <= ksa_j_d;
                  kb_idx_q <= kb_idx_d;
                  state_q  <= ST_KSA_RJ;
               end
               ST_KSA_RJ: state_q <= ST_KSA_LJ;
               ST_KSA_LJ: begin
                  sj_q      <= bus.s_q;
                  s_addr_q  <= i_q;
                  s_wdata_q <= bus.s_q;
                  s_wren_q  <= 1'b1;
                  state_q   <= ST_KSA_WI;
               end
               ST_KSA_WI: begin
                  s_addr_q  <= j_q;
                  s_wdata_q <= si_q;
                  s_wren_q  <= 1'b1;
                  state_q   <= ST_KSA_WJ;
               end
               ST_KSA_WJ: begin
                  if (i_q == 8'hFF) begin
                     // PRGA starts from i=j=0; its first step already uses i=1.
                     i_q        <= 8'h01;
                     j_q        <= 8'h00;
                     k_q        <= 8'h00;
                     msg_addr_q <= {MA_W{1'b0}};
                     s_addr_q   <= 8'h01;
                     state_q    <= ST_PRGA_RI;
                  end else begin
                     i_q      <= i_inc_d;
                     s_addr_q <= i_inc_d;
                     state_q  <= ST_KSA_RI;
                  end
               end
               ST_PRGA_RI: state_q <= ST_PRGA_LI;
               ST_PRGA_LI: begin
                  si_q     <= bus.s_q;
                  j_q      <= prga_j_d;
                  s_addr_q <= prga_j_d;
                  state_q  <= ST_PRGA_RJ;
               end
               ST_PRGA_RJ: state_q <= ST_PRGA_LJ;
               ST_PRGA_LJ: begin
                  sj_q      <= bus.s_q;
                  s_addr_q  <= i_q;
                  s_wdata_q <= bus.s_q;
                  s_wren_q  <= 1'b1;
                  state_q   <= ST_PRGA_WI;
               end
               ST_PRGA_WI: begin
                  s_addr_q  <= j_q;
                  s_wdata_q <= si_q;
                  s_wren_q  <= 1'b1;
                  state_q   <= ST_PRGA_WJ;
               end
               ST_PRGA_WJ: begin
                  s_addr_q <= f_idx_d;
                  state_q  <= ST_PRGA_RF;
               end
               ST_PRGA_RF: state_q <= ST_PRGA_LF;
               ST_PRGA_LF: begin
                  dec_addr_q  <= k_q[MA_W-1:0];
                  dec_wdata_q <= p_d;
                  dec_wren_q  <= 1'b1;
                  state_q     <= ST_PRGA_CHK;
               end
               ST_PRGA_CHK: begin
                  // Judged on the byte being written this cycle.
                  if (!is_text(dec_wdata_q)) begin
                     state_q <= ST_NEXT_KEY;
                  end else if (k_q == 8'(MSG_LEN - 1)) begin
                     found_key_q <= cur_key_q;
                     found_q     <= 1'b1;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= ST_DONE;
                  end else begin
                     k_q        <= k_inc_d;
                     msg_addr_q <= k_inc_d[MA_W-1:0];
                     i_q        <= i_inc_d;
                     s_addr_q   <= i_inc_d;
                     state_q    <= ST_PRGA_RI;
                  end
               end
               ST_NEXT_KEY: begin
                  if (key_end_d) begin
                     failed_q <= 1'b1;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= ST_DONE;
                  end else begin
                     cur_key_q <= key_sum_d[KEY_BITS-1:0];
                     s_wren_q  <= 1'b1;
                     s_addr_q  <= 8'h00;
                     s_wdata_q <= 8'h00;
                     state_q   <= ST_INIT;
                  end
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.s_addr    = s_addr_q;
   assign bus.s_wdata   = s_wdata_q;
   assign bus.s_wren    = s_wren_q;
   assign bus.msg_addr  = msg_addr_q;
   assign bus.dec_addr  = dec_addr_q;
   assign bus.dec_wdata = dec_wdata_q;
   assign bus.dec_wren  = dec_wren_q;
   assign bus.cur_key   = cur_key_q;
   assign bus.found_key = found_key_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.found     = found_q;
   assign bus.failed    = failed_q;
endmodule

// File: tb/tb_rc4_keysearch_core.sv
// ----------------------------------------------------------------------------
// Bench for rc4_keysearch_core: four cores with different key ranges run in
// parallel, each with its own S RAM, plaintext RAM and a shared ciphertext
// ROM holding a 32-byte lowercase text encrypted with key 24'h000249.
//   core 0: start 0x240 step 1            -> finds 0x249
//   core 1: start 0x000 step 1 last 0x00F -> fails at 0x00F
//   core 2: start 0x241 step 2            -> finds 0x249
//   core 3: start 0x240 step 2 last 0x24F -> fails at 0x24E
// ----------------------------------------------------------------------------
module tb_rc4_keysearch_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_r   [4];
   logic        start_r   [4];
   logic        stop_r    [4];
   logic        dec_clr_r [4];
   logic [7:0]  cipher    [32];
   string       pt_s;

   logic [3:0]  busy_w, done_w, found_w, failed_w, s_wren_w, dec_wren_w;
   logic [7:0]  s_addr_w  [4];
   logic [7:0]  s_wdata_w [4];
   logic [23:0] cur_key_w [4];
   logic [23:0] found_key_w [4];

   int n_vec = 0;
   int n_err = 0;

   for (genvar g = 0; g < 4; g++) begin : g_core
      localparam logic [23:0] KS = (g == 0) ? 24'h000240 : (g == 1) ? 24'h000000 :
                                   (g == 2) ? 24'h000241 : 24'h000240;
      localparam int unsigned KP = (g >= 2) ? 32'd2 : 32'd1;
      localparam logic [23:0] KL = (g == 1) ? 24'h00000F : (g == 3) ? 24'h00024F : 24'hFFFFFF;

      rc4_keysearch_core_if #(.KEY_BITS(24), .MSG_LEN(32)) bus ();

      rc4_keysearch_core #(
         .KEY_BYTES(3), .KEY_BITS(24), .MSG_LEN(32),
         .KEY_START(KS), .KEY_STEP(KP), .KEY_LAST(KL)
      ) dut (
         .clk     (clk),
         .reset_n (rst_n_r[g]),
         .bus     (bus)
      );

      logic [7:0] s_mem   [256];
      logic [7:0] dec_mem [32];

      assign bus.start = start_r[g];
      assign bus.stop  = stop_r[g];

      // S RAM: synchronous, read-first.
      always @(posedge clk) begin
         if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
         bus.s_q <= s_mem[bus.s_addr];
      end

      // Ciphertext ROM with one cycle of latency.
      always @(posedge clk) bus.msg_q <= cipher[bus.msg_addr];

      // Plaintext RAM, clearable from the bench.
      always @(posedge clk) begin
         if (dec_clr_r[g]) begin
            for (int n = 0; n < 32; n++) dec_mem[n] <= 8'h00;
         end else if (bus.dec_wren) begin
            dec_mem[bus.dec_addr] <= bus.dec_wdata;
         end
      end

      assign busy_w[g]      = bus.busy;
      assign done_w[g]      = bus.done;
      assign found_w[g]     = bus.found;
      assign failed_w[g]    = bus.failed;
      assign s_wren_w[g]    = bus.s_wren;
      assign dec_wren_w[g]  = bus.dec_wren;
      assign s_addr_w[g]    = bus.s_addr;
      assign s_wdata_w[g]   = bus.s_wdata;
      assign cur_key_w[g]   = bus.cur_key;
      assign found_key_w[g] = bus.found_key;
   end

   typedef struct {
      string       name;
      int          inst;
      logic        busy, done, found, failed, s_wren, dec_wren;
      logic [23:0] cur_key;
      logic        chk_fk;
      logic [23:0] found_key;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      chk({v.name, ".busy"},     32'(busy_w[v.inst]),     32'(v.busy));
      chk({v.name, ".done"},     32'(done_w[v.inst]),     32'(v.done));
      chk({v.name, ".found"},    32'(found_w[v.inst]),    32'(v.found));
      chk({v.name, ".failed"},   32'(failed_w[v.inst]),   32'(v.failed));
      chk({v.name, ".s_wren"},   32'(s_wren_w[v.inst]),   32'(v.s_wren));
      chk({v.name, ".dec_wren"}, 32'(dec_wren_w[v.inst]), 32'(v.dec_wren));
      chk({v.name, ".cur_key"},  32'(cur_key_w[v.inst]),  32'(v.cur_key));
      if (v.chk_fk) chk({v.name, ".found_key"}, 32'(found_key_w[v.inst]), 32'(v.found_key));
   endtask

   // Standard RC4 encryption of the plaintext with key 00 02 49.
   task automatic build_cipher();
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] i, j, t;
      kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      j = 8'h00;
      for (int n = 0; n < 256; n++) begin
         j = j + s[n] + kb[n % 3];
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 8'h00; j = 8'h00;
      for (int k = 0; k < 32; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         t = s[i] + s[j];
         cipher[k] = s[t] ^ 8'(pt_s[k]);
      end
   endtask

   task automatic pulse_start(input int g);
      start_r[g] = 1'b1;
      @(negedge clk);
      start_r[g] = 1'b0;
   endtask

   task automatic check_dec(input string tag);
      for (int n = 0; n < 32; n++)
         chk($sformatf("%s[%0d]", tag, n), 32'(g_core[0].dec_mem[n]), 32'(pt_s[n]));
   endtask

   initial begin
      int bad;
      int cnt;
      logic seen;

      pt_s = "the quick brown fox jumps over t";
      //            name         inst busy done fnd  fail swr  dwr  cur_key      chkfk found_key
      tbl[0] = '{"rst0",  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000240, 1'b1, 24'h000000};
      tbl[1] = '{"rst1",  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 24'h000000};
      tbl[2] = '{"rst2",  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000241, 1'b1, 24'h000000};
      tbl[3] = '{"rst3",  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000240, 1'b1, 24'h000000};
      tbl[4] = '{"find",  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000249, 1'b1, 24'h000249};
      tbl[5] = '{"exh",   1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00000F, 1'b0, 24'h000000};
      tbl[6] = '{"ilv_f", 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000249, 1'b1, 24'h000249};
      tbl[7] = '{"ilv_x", 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00024E, 1'b0, 24'h000000};

      build_cipher();
      for (int g = 0; g < 4; g++) begin
         rst_n_r[g] = 1'b0; start_r[g] = 1'b0; stop_r[g] = 1'b0; dec_clr_r[g] = 1'b0;
      end

      // Power-up.
      repeat (3) @(negedge clk);
      for (int g = 0; g < 4; g++) rst_n_r[g] = 1'b1;
      repeat (2) @(negedge clk);
      for (int v = 0; v < 4; v++) apply_vec(tbl[v]);

      // Start all cores; core 0 INIT sequence must be 256 writes addr==data==n.
      for (int g = 0; g < 4; g++) start_r[g] = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 4; g++) start_r[g] = 1'b0;
      chk("init_busy", 32'(busy_w[0]), 32'd1);
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         if (!(s_wren_w[0] === 1'b1 && s_addr_w[0] === 8'(n) && s_wdata_w[0] === 8'(n))) bad++;
         @(negedge clk);
      end
      chk("init_seq_errors", 32'(bad), 32'd0);
      chk("init_end_wren", 32'(s_wren_w[0]), 32'd0);

      // Run all searches to completion.
      for (int c = 0; c < 60000 && done_w != 4'hF; c++) @(negedge clk);
      chk("all_done", 32'(done_w), 32'hF);
      for (int v = 4; v < 8; v++) apply_vec(tbl[v]);
      check_dec("decA");

      // Abort mid-KSA on core 0.
      pulse_start(0);
      repeat (400) @(negedge clk);
      chk("ksa_busy", 32'(busy_w[0]), 32'd1);
      stop_r[0] = 1'b1;
      @(negedge clk);
      stop_r[0] = 1'b0;
      chk("stop_busy",   32'(busy_w[0]),     32'd0);
      chk("stop_done",   32'(done_w[0]),     32'd1);
      chk("stop_found",  32'(found_w[0]),    32'd0);
      chk("stop_failed", 32'(failed_w[0]),   32'd0);
      chk("stop_s_wren", 32'(s_wren_w[0]),   32'd0);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         cnt += int'(s_wren_w[0]) + int'(dec_wren_w[0]);
      end
      chk("stop_no_writes", 32'(cnt), 32'd0);

      // start and stop together: stop wins, core stays idle.
      start_r[0] = 1'b1; stop_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0; stop_r[0] = 1'b0;
      chk("startstop_busy", 32'(busy_w[0]),   32'd0);
      chk("startstop_wren", 32'(s_wren_w[0]), 32'd0);
      chk("startstop_done", 32'(done_w[0]),   32'd1);

      // Reset mid-PRGA: outputs clear without waiting for a clock edge.
      pulse_start(0);
      seen = 1'b0;
      for (int c = 0; c < 4000 && !seen; c++) begin
         if (dec_wren_w[0] === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("prga_reached", 32'(seen), 32'd1);
      #1 rst_n_r[0] = 1'b0;
      #1;
      chk("arst_busy",     32'(busy_w[0]),     32'd0);
      chk("arst_done",     32'(done_w[0]),     32'd0);
      chk("arst_found",    32'(found_w[0]),    32'd0);
      chk("arst_dec_wren", 32'(dec_wren_w[0]), 32'd0);
      chk("arst_cur_key",  32'(cur_key_w[0]),  32'h000240);
      @(negedge clk);
      rst_n_r[0] = 1'b1;
      dec_clr_r[0] = 1'b1;
      @(negedge clk);
      dec_clr_r[0] = 1'b0;

      // Repeat the find after reset.
      pulse_start(0);
      for (int c = 0; c < 40000 && done_w[0] !== 1'b1; c++) @(negedge clk);
      chk("rerun_done",      32'(done_w[0]),      32'd1);
      chk("rerun_found",     32'(found_w[0]),     32'd1);
      chk("rerun_failed",    32'(failed_w[0]),    32'd0);
      chk("rerun_busy",      32'(busy_w[0]),      32'd0);
      chk("rerun_found_key", 32'(found_key_w[0]), 32'h000249);
      check_dec("decA_rerun");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
